// File: rtl/harness_run_ctrl.sv
// ---------------------------------------------------------------------------
// harness_run_ctrl
//
// Run controller for the test harness. It holds the DUT in reset for a fixed
// number of cycles, then counts run cycles until the tester asks to stop or
// the watchdog expires. After a short drain period it presents a sticky
// done/pass/fail result to the simulation top.
//
// Ports:
//   clock        harness clock from the simulation top
//   reset_n      asynchronous, active-low reset
//   dut_reset    active-high reset to the DUT (registered)
//   stop_valid   tester requests end of run
//   stop_code    tester result, 0 = pass, nonzero = failure code
//   stop_ready   controller can accept a stop (high only in RUN)
//   running      high while in RUN
//   cycle_count  RUN cycles elapsed, saturating
//   done         run finished (sticky)
//   pass         run passed, valid when done = 1
//   fail_code    captured stop_code, or 0xFF on watchdog timeout
//   timeout      watchdog fired (sticky)
// ---------------------------------------------------------------------------
module harness_run_ctrl #(
    parameter int unsigned RESET_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned DRAIN_CYCLES   = 2,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic             dut_reset,
    input  logic             stop_valid,
    input  logic [7:0]       stop_code,
    output logic             stop_ready,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic             pass,
    output logic [7:0]       fail_code,
    output logic             timeout
);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Terminal counts are pre-computed so each phase ends on the edge
    // where the counter reaches "length - 1".
    localparam logic [7:0]       HOLD_LAST  = 8'(RESET_CYCLES - 1);
    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [63:0]      WDOG_LAST  = 64'(TIMEOUT_CYCLES) - 64'd1;
    localparam logic             WDOG_ON    = (TIMEOUT_CYCLES != 0);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [3:0] drain_cnt;
    logic       stop_fire;
    logic       wdog_fire;

    // stop_ready is only ever high in RUN, so it gates the handshake; the
    // state term keeps the intent obvious and guards against stale values.
    assign stop_fire = stop_valid && stop_ready && (state == RUN);

    // Comparison is done at 64 bits so a narrow counter never aliases onto
    // a wider timeout value.
    assign wdog_fire = WDOG_ON && (state == RUN) && (64'(cycle_count) == WDOG_LAST);

    // Single sequencer: every output is a register updated on the state
    // transitions. A stop accepted on the same edge as the watchdog limit
    // wins, so the tester's code is reported instead of a timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HOLD;
            hold_cnt    <= 8'd0;
            drain_cnt   <= 4'd0;
            dut_reset   <= 1'b1;
            stop_ready  <= 1'b0;
            running     <= 1'b0;
            cycle_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= 8'h00;
            timeout     <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= RUN;
                        dut_reset  <= 1'b0;
                        running    <= 1'b1;
                        stop_ready <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                RUN: begin
                    // The accepting / timing-out edge still counts as a run cycle.
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_ONE;
                    end
                    if (stop_fire) begin
                        state      <= DRAIN;
                        fail_code  <= stop_code;
                        stop_ready <= 1'b0;
                        running    <= 1'b0;
                        drain_cnt  <= 4'd0;
                    end else if (wdog_fire) begin
                        state      <= DRAIN;
                        fail_code  <= 8'hFF;
                        timeout    <= 1'b1;
                        stop_ready <= 1'b0;
                        running    <= 1'b0;
                        drain_cnt  <= 4'd0;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (fail_code == 8'h00) && !timeout;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end

                DONE: begin
                    state <= DONE;
                end

                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_harness_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_harness_run_ctrl
//
// Bench for harness_run_ctrl. Three instances share clock and reset:
//   A: defaults
//   B: TIMEOUT_CYCLES = 20
//   C: CNT_W = 4, watchdog disabled
// Expected end-of-run results are queued when a run is set up and compared
// when the selected instance raises done.
// ---------------------------------------------------------------------------
module tb_harness_run_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset_n;
    logic [2:0]       stop_valid;
    logic [2:0][7:0]  stop_code;
    logic [2:0]       dut_reset;
    logic [2:0]       stop_ready;
    logic [2:0]       running;
    logic [2:0]       done;
    logic [2:0]       pass;
    logic [2:0][7:0]  fail_code;
    logic [2:0]       timeout;
    logic [31:0]      count_a;
    logic [31:0]      count_b;
    logic [3:0]       count_c;

    harness_run_ctrl dut_a (
        .clock(clock), .reset_n(reset_n), .dut_reset(dut_reset[0]),
        .stop_valid(stop_valid[0]), .stop_code(stop_code[0]), .stop_ready(stop_ready[0]),
        .running(running[0]), .cycle_count(count_a), .done(done[0]), .pass(pass[0]),
        .fail_code(fail_code[0]), .timeout(timeout[0])
    );

    harness_run_ctrl #(.TIMEOUT_CYCLES(20)) dut_b (
        .clock(clock), .reset_n(reset_n), .dut_reset(dut_reset[1]),
        .stop_valid(stop_valid[1]), .stop_code(stop_code[1]), .stop_ready(stop_ready[1]),
        .running(running[1]), .cycle_count(count_b), .done(done[1]), .pass(pass[1]),
        .fail_code(fail_code[1]), .timeout(timeout[1])
    );

    harness_run_ctrl #(.TIMEOUT_CYCLES(0), .CNT_W(4)) dut_c (
        .clock(clock), .reset_n(reset_n), .dut_reset(dut_reset[2]),
        .stop_valid(stop_valid[2]), .stop_code(stop_code[2]), .stop_ready(stop_ready[2]),
        .running(running[2]), .cycle_count(count_c), .done(done[2]), .pass(pass[2]),
        .fail_code(fail_code[2]), .timeout(timeout[2])
    );

    typedef struct {
        int          dut;
        logic        pass;
        logic [7:0]  code;
        logic        to;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] countOf(input int d);
        case (d)
            0:       return count_a;
            1:       return count_b;
            default: return {28'd0, count_c};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int d, input logic [7:0] code);
        stop_valid[d] = 1'b1;
        stop_code[d]  = code;
    endtask

    task automatic pushExpect(input int d, input logic p, input logic [7:0] code,
                              input logic to, input logic [31:0] count);
        exp_t e;
        e.dut   = d;
        e.pass  = p;
        e.code  = code;
        e.to    = to;
        e.count = count;
        sb.push_back(e);
    endtask

    task automatic checkResetValues(input string tag);
        for (int d = 0; d < 3; d++) begin
            checkOutput({tag, "_dut_reset"},  dut_reset[d],  1);
            checkOutput({tag, "_stop_ready"}, stop_ready[d], 0);
            checkOutput({tag, "_running"},    running[d],    0);
            checkOutput({tag, "_count"},      countOf(d),    0);
            checkOutput({tag, "_done"},       done[d],       0);
            checkOutput({tag, "_pass"},       pass[d],       0);
            checkOutput({tag, "_fail_code"},  fail_code[d],  0);
            checkOutput({tag, "_timeout"},    timeout[d],    0);
        end
    endtask

    // Asserts reset away from the clock edge, checks reset values, releases.
    task automatic resetSeq(input string tag);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkResetValues(tag);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // dut_reset must stay high for RESET_CYCLES-1 edges and fall on the 5th.
    task automatic holdPhase(input int d);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput("hold_dut_reset",  dut_reset[d],  (i < 5) ? 1 : 0);
            checkOutput("hold_stop_ready", stop_ready[d], (i == 5) ? 1 : 0);
            checkOutput("hold_running",    running[d],    (i == 5) ? 1 : 0);
        end
    endtask

    task automatic waitCount(input int d, input logic [31:0] target, input int budget);
        int n = 0;
        while (countOf(d) != target && n < budget) begin
            tick();
            n++;
        end
        checkOutput("reach_count", countOf(d), target);
    endtask

    task automatic collectResult(input int d, input int budget);
        exp_t e;
        int   n = 0;
        while (!done[d] && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_seen", done[d], 1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_underflow observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            checkOutput("sb_dut",    d,            e.dut);
            checkOutput("pass",      pass[d],      e.pass);
            checkOutput("fail_code", fail_code[d], e.code);
            checkOutput("timeout",   timeout[d],   e.to);
            checkOutput("count",     countOf(d),   e.count);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_time_limit observed=expired expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        reset_n    = 1'b1;
        stop_valid = '0;
        stop_code  = '0;

        // Normal run with a passing stop at cycle_count = 10.
        $display("[TB] scenario: pass stop");
        resetSeq("rst1");
        holdPhase(0);
        tick();
        checkOutput("first_run_count", count_a, 1);
        waitCount(0, 10, 50);
        applyStimulus(0, 8'h00);
        pushExpect(0, 1'b1, 8'h00, 1'b0, 11);
        tick();
        stop_valid[0] = 1'b0;
        checkOutput("accept_stop_ready", stop_ready[0], 0);
        checkOutput("accept_running",    running[0],    0);
        checkOutput("accept_count",      count_a,       11);
        checkOutput("drain1_done",       done[0],       0);
        tick();
        checkOutput("drain2_done",       done[0],       0);
        checkOutput("drain_count",       count_a,       11);
        tick();
        checkOutput("done_latency",      done[0],       1);
        collectResult(0, 0);
        // DONE is terminal: a late stop must not change anything.
        applyStimulus(0, 8'h55);
        for (int i = 0; i < 3; i++) tick();
        stop_valid[0] = 1'b0;
        checkOutput("terminal_fail_code", fail_code[0], 8'h00);
        checkOutput("terminal_done",      done[0],      1);
        checkOutput("terminal_count",     count_a,      11);

        // Watchdog expiry on instance B.
        $display("[TB] scenario: watchdog");
        resetSeq("rst2");
        holdPhase(1);
        pushExpect(1, 1'b0, 8'hFF, 1'b1, 20);
        waitCount(1, 19, 40);
        tick();
        checkOutput("wdog_count",   count_b,    20);
        checkOutput("wdog_running", running[1], 0);
        checkOutput("wdog_timeout", timeout[1], 1);
        tick();
        checkOutput("wdog_drain_done", done[1], 0);
        tick();
        checkOutput("wdog_done_latency", done[1], 1);
        collectResult(1, 0);
        tick();
        checkOutput("wdog_count_held", count_b, 20);

        // Stop on the same edge the watchdog would fire: stop wins.
        $display("[TB] scenario: stop vs watchdog");
        resetSeq("rst3");
        holdPhase(1);
        waitCount(1, 19, 40);
        applyStimulus(1, 8'h2A);
        pushExpect(1, 1'b0, 8'h2A, 1'b0, 20);
        tick();
        stop_valid[1] = 1'b0;
        checkOutput("race_timeout",   timeout[1],   0);
        checkOutput("race_fail_code", fail_code[1], 8'h2A);
        collectResult(1, 4);

        // Stop held from reset is ignored during HOLD, taken on first RUN edge.
        $display("[TB] scenario: early stop");
        applyStimulus(0, 8'h03);
        resetSeq("rst4");
        holdPhase(0);
        pushExpect(0, 1'b0, 8'h03, 1'b0, 1);
        tick();
        stop_valid[0] = 1'b0;
        checkOutput("early_count",      count_a,       1);
        checkOutput("early_stop_ready", stop_ready[0], 0);
        collectResult(0, 4);

        // Reset pulse during DRAIN takes effect without a clock edge.
        $display("[TB] scenario: reset in drain");
        resetSeq("rst5");
        holdPhase(0);
        waitCount(0, 3, 20);
        applyStimulus(0, 8'h11);
        tick();
        stop_valid[0] = 1'b0;
        checkOutput("mid_in_drain", running[0], 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues("async");
        @(negedge clock);
        reset_n = 1'b1;
        holdPhase(0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("after_abort_done", done[0], 0);

        // Narrow counter saturates at 15 with the watchdog disabled.
        $display("[TB] scenario: saturation");
        waitCount(2, 15, 40);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("sat_count", count_c, 15);
        end
        checkOutput("sat_timeout", timeout[2], 0);
        checkOutput("sat_done",    done[2],    0);
        applyStimulus(2, 8'h00);
        pushExpect(2, 1'b1, 8'h00, 1'b0, 15);
        tick();
        stop_valid[2] = 1'b0;
        collectResult(2, 4);

        checkOutput("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
